// File: rtl/vae_pkg.sv
// Shared fixed-point constants, LFSR parameters and saturation helper for the
// VAE sampling datapath (signed Q8.8).
package vae_pkg;

  localparam int WIDTH = 16;
  localparam int FRAC  = 8;

  localparam logic [15:0] Q_ONE = 16'h0100;
  localparam logic [15:0] Q_MAX = 16'h7FFF;
  localparam logic [15:0] Q_MIN = 16'h8000;

  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
  localparam int          CLT_OFFSET = 510;

  typedef struct packed {
    logic signed [15:0] mu;
    logic signed [15:0] scale;
    logic signed [15:0] eps;
  } s1_t;

  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767) begin
      return Q_MAX;
    end else if (v < -32'sd32768) begin
      return Q_MIN;
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/eps_gen.sv
// Galois LFSR plus byte-sum CLT shaping; eps reflects the current LFSR state
// and the state advances once per consumed epsilon.
module eps_gen #(
  parameter logic [31:0] SEED = 32'hACE1_2024
) (
  input  logic                               clock,
  input  logic                               rst,
  input  logic                               advance,
  input  logic                               seed_load,
  input  logic [31:0]                        seed,
  output logic signed [vae_pkg::WIDTH-1:0]   eps
);
  import vae_pkg::*;

  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

  logic [31:0]        lfsr_q;
  logic [31:0]        lfsr_d;
  logic [31:0]        lfsr_next;
  logic [9:0]         byte_sum;
  logic signed [11:0] dev;
  logic signed [11:0] eps_w;

  always_comb begin
    lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);
    lfsr_d    = lfsr_q;
    // a zero state would lock the LFSR up, so it is replaced by 1
    if (seed_load) begin
      lfsr_d = (seed == 32'd0) ? 32'd1 : seed;
    end else if (advance) begin
      lfsr_d = lfsr_next;
    end
  end

  always_comb begin
    byte_sum = 10'(lfsr_q[31:24]) + 10'(lfsr_q[23:16])
             + 10'(lfsr_q[15:8])  + 10'(lfsr_q[7:0]);
    dev      = $signed({2'b00, byte_sum}) - $signed(12'(CLT_OFFSET));
    // ~1.75 * dev brings the byte-sum spread close to unit variance
    eps_w    = dev + (dev >>> 1) + (dev >>> 2);
    eps      = {{(WIDTH-12){eps_w[11]}}, eps_w};
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      lfsr_q <= SEED_EFF;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/reparam_sampler.sv
// Reparameterisation stage z = mu + scale*eps: two-slot valid/ready pipeline
// with full backpressure, one sample per clock at full rate.
module reparam_sampler #(
  parameter int          WIDTH = 16,
  parameter logic [31:0] SEED  = 32'hACE1_2024
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [WIDTH-1:0]  mu,
  input  logic signed [WIDTH-1:0]  scale,
  input  logic                     seed_load,
  input  logic [31:0]              seed,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [WIDTH-1:0]  z,
  output logic signed [WIDTH-1:0]  eps_out
);
  import vae_pkg::*;

  // datapath arithmetic is sized for WIDTH == 16 (Q8.8)
  logic               s1_valid_q;
  s1_t                s1_q;
  logic               out_valid_q;
  logic signed [15:0] z_q;
  logic signed [15:0] eps_out_q;

  logic               out_free;
  logic               move;
  logic               accept;
  logic signed [15:0] eps_cur;

  logic signed [31:0] prod;
  logic signed [31:0] prod_rnd;
  logic signed [15:0] r_sat;
  logic signed [16:0] sum17;
  logic signed [15:0] z_d;

  assign out_free  = !out_valid_q || out_ready;
  assign move      = s1_valid_q && out_free;
  assign in_ready  = !s1_valid_q || out_free;
  assign accept    = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign z         = z_q;
  assign eps_out   = eps_out_q;

  eps_gen #(
    .SEED (SEED)
  ) u_eps_gen (
    .clock     (clock),
    .rst       (rst),
    .advance   (accept),
    .seed_load (seed_load),
    .seed      (seed),
    .eps       (eps_cur)
  );

  always_comb begin
    prod     = $signed(s1_q.scale) * $signed(s1_q.eps);
    prod_rnd = (prod + 32'sd128) >>> FRAC;
    r_sat    = sat16(prod_rnd);
    sum17    = {s1_q.mu[15], s1_q.mu} + {r_sat[15], r_sat};
    z_d      = sat16(32'(sum17));
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      z_q         <= '0;
      eps_out_q   <= '0;
    end else begin
      if (accept) begin
        s1_q.mu    <= mu;
        s1_q.scale <= scale;
        s1_q.eps   <= eps_cur;
        s1_valid_q <= 1'b1;
      end else if (move) begin
        s1_valid_q <= 1'b0;
      end

      if (move) begin
        out_valid_q <= 1'b1;
        z_q         <= z_d;
        eps_out_q   <= s1_q.eps;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reparam_sampler.sv
// Directed vector table, backpressure/reset sequences and a randomised
// handshake run checked against a reference LFSR/arithmetic model.
module tb_reparam_sampler;

  localparam logic [31:0] SEED = 32'hACE1_2024;

  logic        clock;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] mu;
  logic [15:0] scale;
  logic        seed_load;
  logic [31:0] seed;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] z;
  logic [15:0] eps_out;

  int total = 0;
  int bad   = 0;

  reparam_sampler #(.WIDTH(16), .SEED(SEED)) dut (
    .clock     (clock),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mu        (mu),
    .scale     (scale),
    .seed_load (seed_load),
    .seed      (seed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .eps_out   (eps_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int m_eps(input logic [31:0] l);
    int s;
    int d;
    s = int'(l[31:24]) + int'(l[23:16]) + int'(l[15:8]) + int'(l[7:0]);
    d = s - 510;
    return d + (d >>> 1) + (d >>> 2);
  endfunction

  function automatic logic [31:0] m_step(input logic [31:0] l);
    logic [31:0] sh;
    sh = l >> 1;
    return l[0] ? (sh ^ 32'h8020_0003) : sh;
  endfunction

  function automatic logic [15:0] m_z(input logic [15:0] m, input logic [15:0] sc, input int e);
    longint p;
    longint r;
    longint s;
    p = longint'($signed(sc)) * longint'(e);
    r = (p + 128) >>> 8;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    s = longint'($signed(m)) + r;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  // scoreboard of accepted samples, fed by the model LFSR
  typedef struct {
    logic [15:0] z;
    logic [15:0] eps;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_lfsr = SEED;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_z = '0;
  logic [15:0] prev_eps = '0;
  int          n_acc = 0;

  always @(negedge clock) begin
    if (!rst) begin
      q.delete();
      m_lfsr     = SEED;
      prev_stall = 1'b0;
    end else begin
      chk("mon_in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2) || out_ready});
      if (prev_stall) begin
        chk("mon_stall_valid", {31'd0, out_valid}, 32'd1);
        chk("mon_stall_z", {16'd0, z}, {16'd0, prev_z});
        chk("mon_stall_eps", {16'd0, eps_out}, {16'd0, prev_eps});
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("mon_unexpected_out", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("mon_z", {16'd0, z}, {16'd0, e.z});
          chk("mon_eps", {16'd0, eps_out}, {16'd0, e.eps});
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e.eps = 16'(m_eps(m_lfsr));
        e.z   = m_z(mu, scale, m_eps(m_lfsr));
        q.push_back(e);
        n_acc++;
      end
      if (seed_load) m_lfsr = (seed == 32'd0) ? 32'd1 : seed;
      else if (in_valid && in_ready) m_lfsr = m_step(m_lfsr);
      prev_stall = out_valid && !out_ready;
      prev_z     = z;
      prev_eps   = eps_out;
    end
  end

  // entered and left at posedge+1; one accept, exact one-cycle latency
  task automatic run_single(input string name, input logic [15:0] m, input logic [15:0] sc,
                            input logic [15:0] exp_eps, input logic [15:0] exp_z);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    mu        = m;
    scale     = sc;
    #1 chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    #1 chk({name, "_early"}, {31'd0, out_valid}, 32'd0);
    @(posedge clock); #1;
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_eps"}, {16'd0, eps_out}, {16'd0, exp_eps});
    chk({name, "_z"}, {16'd0, z}, {16'd0, exp_z});
  endtask

  typedef struct {
    logic [31:0] seed;
    logic [15:0] mu;
    logic [15:0] scale;
    logic [15:0] eps;
    logic [15:0] z;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int idx;
    int acc_cnt;
    int n_out;
    int gap;

    vecs[0] = '{32'hFFFF_FF01, 16'h0000, 16'h0100, 16'h01C0, 16'h01C0};
    vecs[1] = '{32'hFFFF_FFFF, 16'h0100, 16'h7FFF, 16'h037C, 16'h7FFF};
    vecs[2] = '{32'h0000_0000, 16'h8000, 16'h0100, 16'hFC84, 16'h8000};
    vecs[3] = '{32'hFFFF_FF01, 16'h0080, 16'h0080, 16'h01C0, 16'h0160};
    vecs[4] = '{32'hFFFF_FF01, 16'h0000, 16'hFF00, 16'h01C0, 16'hFE40};
    vecs[5] = '{32'h0000_0001, 16'h0005, 16'h0001, 16'hFC84, 16'h0002};
    vecs[6] = '{32'h8080_8080, 16'h7F00, 16'h0100, 16'h0003, 16'h7F03};
    vecs[7] = '{32'h7E7E_7E7E, 16'h0000, 16'h0100, 16'hFFF5, 16'hFFF5};

    rst = 1'b0; in_valid = 1'b0; mu = '0; scale = '0;
    seed_load = 1'b0; seed = '0; out_ready = 1'b0;
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_z", {16'd0, z}, 32'd0);
    chk("rst_eps", {16'd0, eps_out}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clock);
    #1 rst = 1'b1;

    // first epsilon after reset comes from SEED: eps = -80
    run_single("seed_first", 16'h0000, 16'h0100, 16'hFFB0, 16'hFFB0);

    for (int i = 0; i < 8; i++) begin
      seed_load = 1'b1;
      seed      = vecs[i].seed;
      @(posedge clock); #1;
      seed_load = 1'b0;
      run_single($sformatf("vec%0d", i), vecs[i].mu, vecs[i].scale, vecs[i].eps, vecs[i].z);
    end

    // backpressure: only two samples fit while out_ready is low
    seed_load = 1'b1; seed = 32'h1234_5678; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clock); #1;
    seed_load = 1'b0; out_ready = 1'b0;
    idx = 0; acc_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; mu = 16'(idx * 256); scale = 16'(16'h0100 + idx);
      #1;
      if (in_ready) begin idx++; acc_cnt++; end
      @(posedge clock); #1;
    end
    chk("bp_accepts", acc_cnt, 32'd2);
    mu = 16'(idx * 256); scale = 16'(16'h0100 + idx);
    #1 chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1; n_out = 0; gap = 0;
    for (int c = 0; c < 20; c++) begin
      if (idx < 5) begin
        in_valid = 1'b1; mu = 16'(idx * 256); scale = 16'(16'h0100 + idx);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) idx++;
      if (out_valid) n_out++;
      else if (n_out > 0 && n_out < 5) gap++;
      @(posedge clock); #1;
    end
    chk("bp_outputs", n_out, 32'd5);
    chk("bp_gaps", gap, 32'd0);
    chk("bp_all_accepted", idx, 32'd5);

    // reset with two samples in flight
    out_ready = 1'b0; in_valid = 1'b1; mu = 16'h0100; scale = 16'h0100;
    repeat (2) begin @(posedge clock); #1; end
    in_valid = 1'b0;
    #1 chk("mid_full", {31'd0, out_valid}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_z", {16'd0, z}, 32'd0);
    @(posedge clock); #1;
    rst = 1'b1;
    run_single("mid_seed", 16'h0000, 16'h0100, 16'hFFB0, 16'hFFB0);

    // randomised handshake with occasional reseeding
    n_acc = 0;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      mu        = 16'($urandom);
      scale     = 16'($urandom);
      seed_load = ($urandom_range(0, 63) == 0);
      seed      = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      @(posedge clock); #1;
    end
    in_valid = 1'b0; seed_load = 1'b0; out_ready = 1'b1;
    repeat (4) begin @(posedge clock); #1; end
    chk("rand_drained", q.size(), 32'd0);
    chk("rand_activity", {31'd0, n_acc > 3000}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
